// File: rtl/regex_thread_fifo_pkg.sv
// Shared widths and the thread payload for the regex thread FIFO.
package regex_thread_fifo_pkg;

    localparam int unsigned PC_WIDTH        = 8;
    localparam int unsigned CC_ID_BITS      = 2;
    localparam int unsigned FIFO_DEPTH_LOG2 = 4;
    localparam int unsigned FIFO_DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned COUNT_W         = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned THREAD_WIDTH    = CC_ID_BITS + PC_WIDTH;

    typedef struct packed {
        logic [CC_ID_BITS-1:0] cc_id;
        logic [PC_WIDTH-1:0]   pc;
    } thread_t;

endpackage

// File: rtl/regex_thread_fifo_if.sv
// Seed, CPU push/pop handshakes and status between the controller/CPU and the thread FIFO.
interface regex_thread_fifo_if;
    import regex_thread_fifo_pkg::*;

    logic                      seed_valid;
    logic [CC_ID_BITS-1:0]     seed_cc_id;
    logic [PC_WIDTH-1:0]       seed_pc;
    logic                      seed_ready;
    logic                      push_valid;
    logic [CC_ID_BITS-1:0]     push_cc_id;
    logic [PC_WIDTH-1:0]       push_pc;
    logic                      push_ready;
    logic                      pop_valid;
    logic [CC_ID_BITS-1:0]     pop_cc_id;
    logic [PC_WIDTH-1:0]       pop_pc;
    logic                      pop_ready;
    logic                      flush;
    logic [COUNT_W-1:0]        count;
    logic                      empty;
    logic                      full;

    modport master (
        output seed_valid, seed_cc_id, seed_pc, push_valid, push_cc_id, push_pc,
               pop_ready, flush,
        input  seed_ready, push_ready, pop_valid, pop_cc_id, pop_pc, count, empty, full
    );

    modport slave (
        input  seed_valid, seed_cc_id, seed_pc, push_valid, push_cc_id, push_pc,
               pop_ready, flush,
        output seed_ready, push_ready, pop_valid, pop_cc_id, pop_pc, count, empty, full
    );

endinterface

// File: rtl/regex_thread_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module regex_thread_fifo_mem #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents need no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/regex_thread_fifo.sv
// Circular thread FIFO between regex_cpu output_pc and input_pc, with seed injection.
module regex_thread_fifo
    import regex_thread_fifo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    regex_thread_fifo_if.slave bus
);

    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [COUNT_W-1:0]         r_count;

    logic    w_empty;
    logic    w_full;
    logic    w_seed_ready;
    logic    w_push_ready;
    logic    w_seed_fire;
    logic    w_push_fire;
    logic    w_wr_en;
    logic    w_pop_fire;
    thread_t w_wr_data;
    thread_t w_rd_data;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == COUNT_W'(FIFO_DEPTH));
    // Seed wins arbitration; push_ready looks at seed_valid only, never push_valid.
    assign w_seed_ready = !w_full && !bus.flush;
    assign w_push_ready = !w_full && !bus.flush && !bus.seed_valid;
    assign w_seed_fire  = bus.seed_valid && w_seed_ready;
    assign w_push_fire  = bus.push_valid && w_push_ready;
    assign w_wr_en      = w_seed_fire || w_push_fire;
    assign w_pop_fire   = !w_empty && bus.pop_ready && !bus.flush;

    always_comb begin
        w_wr_data = '0;
        if (w_seed_fire) begin
            w_wr_data.cc_id = bus.seed_cc_id;
            w_wr_data.pc    = bus.seed_pc;
        end else begin
            w_wr_data.cc_id = bus.push_cc_id;
            w_wr_data.pc    = bus.push_pc;
        end
    end

    regex_thread_fifo_mem #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (THREAD_WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (THREAD_WIDTH'(w_wr_data)),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
            end
            if (w_pop_fire) begin
                r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
            end
            case ({w_wr_en, w_pop_fire})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.seed_ready = w_seed_ready;
    assign bus.push_ready = w_push_ready;
    assign bus.pop_valid  = !w_empty;
    assign bus.pop_cc_id  = w_rd_data.cc_id;
    assign bus.pop_pc     = w_rd_data.pc;
    assign bus.count      = r_count;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;

endmodule

// File: tb/tb_regex_thread_fifo.sv
// Scoreboard bench for regex_thread_fifo: directed stimulus queues expected threads, a monitor checks pops.
module tb_regex_thread_fifo;
    import regex_thread_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regex_thread_fifo_if bus();

    regex_thread_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    thread_t exp_q[$];
    int      n_checks = 0;
    int      n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Inputs change 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic thread_t mk(input int cc, input int pc);
        thread_t t;
        t.cc_id = CC_ID_BITS'(cc);
        t.pc    = PC_WIDTH'(pc);
        return t;
    endfunction

    // Monitor: a pop completes at the next edge when these hold at the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.pop_valid && bus.pop_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 1, 0);
            end else begin
                thread_t e;
                e = exp_q.pop_front();
                check("pop_pc", int'(bus.pop_pc), int'(e.pc));
                check("pop_cc_id", int'(bus.pop_cc_id), int'(e.cc_id));
            end
        end
    end

    task automatic push_n(input int n, input int pc0);
        for (int i = 0; i < n; i++) begin
            bus.push_valid = 1'b1;
            bus.push_pc    = PC_WIDTH'(pc0 + i);
            bus.push_cc_id = CC_ID_BITS'(i % 4);
            exp_q.push_back(mk(i % 4, pc0 + i));
            step();
        end
        bus.push_valid = 1'b0;
    endtask

    task automatic drain();
        bus.pop_ready = 1'b1;
        for (int k = 0; k < 40 && bus.pop_valid; k++) step();
        bus.pop_ready = 1'b0;
        check("drain_empty", int'(bus.empty), 1);
    endtask

    initial begin
        bus.seed_valid = 1'b0;
        bus.seed_cc_id = '0;
        bus.seed_pc    = '0;
        bus.push_valid = 1'b0;
        bus.push_cc_id = '0;
        bus.push_pc    = '0;
        bus.pop_ready  = 1'b0;
        bus.flush      = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_count", int'(bus.count), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_full", int'(bus.full), 0);
        check("rst_pop_valid", int'(bus.pop_valid), 0);
        check("rst_seed_ready", int'(bus.seed_ready), 1);
        check("rst_push_ready", int'(bus.push_ready), 1);

        // Single seed, visible the following cycle
        bus.seed_valid = 1'b1;
        bus.seed_pc    = 8'd0;
        bus.seed_cc_id = 2'd0;
        #1;
        check("seed0_ready", int'(bus.seed_ready), 1);
        check("seed0_no_bypass", int'(bus.pop_valid), 0);
        exp_q.push_back(mk(0, 0));
        step();
        bus.seed_valid = 1'b0;
        check("seed0_pop_valid", int'(bus.pop_valid), 1);
        check("seed0_pop_pc", int'(bus.pop_pc), 0);
        check("seed0_count", int'(bus.count), 1);
        drain();

        // Seed and push in the same cycle: seed wins, push waits
        bus.seed_valid = 1'b1;
        bus.seed_pc    = 8'd5;
        bus.seed_cc_id = 2'd1;
        bus.push_valid = 1'b1;
        bus.push_pc    = 8'd9;
        bus.push_cc_id = 2'd2;
        #1;
        check("arb_seed_ready", int'(bus.seed_ready), 1);
        check("arb_push_ready", int'(bus.push_ready), 0);
        exp_q.push_back(mk(1, 5));
        step();
        bus.seed_valid = 1'b0;
        #1;
        check("arb_push_ready2", int'(bus.push_ready), 1);
        exp_q.push_back(mk(2, 9));
        step();
        bus.push_valid = 1'b0;
        check("arb_count", int'(bus.count), 2);
        drain();

        // Fill to 16, then a pop while full must not let the offered push through
        push_n(16, 0);
        check("full_flag", int'(bus.full), 1);
        check("full_count", int'(bus.count), 16);
        bus.push_valid = 1'b1;
        bus.push_pc    = 8'd99;
        bus.push_cc_id = 2'd3;
        #1;
        check("full_push_ready", int'(bus.push_ready), 0);
        check("full_seed_ready", int'(bus.seed_ready), 0);
        step();
        check("full_held_count", int'(bus.count), 16);
        bus.pop_ready = 1'b1;
        #1;
        check("full_pop_push_ready", int'(bus.push_ready), 0);
        step();
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        check("full_after_pop_count", int'(bus.count), 15);
        drain();
        check("full_drain_count", int'(bus.count), 0);

        // Wrap-around with occupancy held at 3
        push_n(3, 100);
        bus.pop_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.push_valid = 1'b1;
            bus.push_pc    = PC_WIDTH'(103 + k);
            bus.push_cc_id = CC_ID_BITS'(k % 4);
            exp_q.push_back(mk(k % 4, 103 + k));
            step();
            check("wrap_count", int'(bus.count), 3);
        end
        bus.push_valid = 1'b0;
        drain();

        // Flush overrides simultaneous push and pop
        push_n(7, 20);
        check("pre_flush_count", int'(bus.count), 7);
        bus.flush      = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_pc    = 8'd50;
        bus.pop_ready  = 1'b1;
        #1;
        check("flush_push_ready", int'(bus.push_ready), 0);
        check("flush_seed_ready", int'(bus.seed_ready), 0);
        step();
        bus.flush      = 1'b0;
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        exp_q.delete();
        check("flush_count", int'(bus.count), 0);
        check("flush_empty", int'(bus.empty), 1);
        check("flush_pop_valid", int'(bus.pop_valid), 0);
        bus.push_valid = 1'b1;
        bus.push_pc    = 8'd3;
        bus.push_cc_id = 2'd1;
        exp_q.push_back(mk(1, 3));
        step();
        bus.push_valid = 1'b0;
        drain();

        // Reset mid-stream
        push_n(5, 60);
        check("pre_rst_count", int'(bus.count), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_count", int'(bus.count), 0);
        check("mid_rst_pop_valid", int'(bus.pop_valid), 0);
        check("mid_rst_push_ready", int'(bus.push_ready), 1);
        check("mid_rst_seed_ready", int'(bus.seed_ready), 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
